// File: rtl/matrix_mult_sequencer_if.sv
// ---------------------------------------------------------------------------
// matrix_mult_sequencer_if
//   Avalon-MM style bus between the matrix-multiply sequencer (master) and
//   the partial-matrix-multiply slave.
//   avm_cs     chip select
//   avm_addr   slave register address (0=A row, 1=B column, 2=result)
//   avm_write  write strobe
//   avm_read   read strobe
//   avm_wdata  write data (packed 4 x 8-bit operand word)
//   avm_rdata  read data, valid the cycle after avm_read
// ---------------------------------------------------------------------------
interface matrix_mult_sequencer_if;
    logic        avm_cs;
    logic [1:0]  avm_addr;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_wdata;
    logic [31:0] avm_rdata;

    modport master (
        output avm_cs, avm_addr, avm_write, avm_read, avm_wdata,
        input  avm_rdata
    );

    modport slave (
        input  avm_cs, avm_addr, avm_write, avm_read, avm_wdata,
        output avm_rdata
    );
endinterface

// File: rtl/matrix_mult_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_mult_sequencer
//   Bus master that computes the 4x4 product C = A*B element by element using
//   a partial-matrix-multiply slave. For each k = {i,j} (row-major) it writes
//   A row i, writes B column j, reads the dot product and stores it in a
//   16-entry result buffer.
//
//   Optional feature macro: MMS_CHECKSUM_EN
//     defined   : checksum accumulates the 16 results of the last run
//     undefined : no accumulator, checksum tied to zero
//
// Ports
//   _CLK       clock, rising edge
//   _RST       asynchronous active-high reset
//   load_en    write one packed operand word into the local store (IDLE only)
//   load_sel   0 = A row, 1 = B column
//   load_idx   row / column index
//   load_data  4 x 8-bit unsigned elements, element 0 in [7:0]
//   start      one-cycle request to compute C (accepted in IDLE only)
//   busy       high while sequencing
//   done       one-cycle pulse after all 16 results are stored
//   res_idx    result read index {i,j}
//   res_data   C[i][j], registered, one-cycle read latency
//   checksum   modular sum of the 16 results of the last run
//   avm        master side of the slave bus
// ---------------------------------------------------------------------------
module matrix_mult_sequencer #(
    parameter int         RES_W  = 18,
    parameter int         CHK_W  = 22,
    parameter logic [1:0] ADDR_A = 2'd0,
    parameter logic [1:0] ADDR_B = 2'd1,
    parameter logic [1:0] ADDR_R = 2'd2
) (
    input  logic             _CLK,
    input  logic             _RST,
    input  logic             load_en,
    input  logic             load_sel,
    input  logic [1:0]       load_idx,
    input  logic [31:0]      load_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       res_idx,
    output logic [RES_W-1:0] res_data,
    output logic [CHK_W-1:0] checksum,
    matrix_mult_sequencer_if.master avm
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_B = 3'd2,
        S_RD   = 3'd3,
        S_CAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [3:0]       k_r, k_s;
    logic [31:0]      a_mem_r [4];
    logic [31:0]      b_mem_r [4];
    logic [RES_W-1:0] buf_r   [16];
    logic [RES_W-1:0] res_data_r;

    logic             load_ok_s;
    logic [31:0]      a_word_s;
    logic             busy_s;
    logic             cs_s, write_s, read_s;
    logic [1:0]       addr_s;
    logic [31:0]      wdata_s;

    logic             busy_r, done_r;
    logic             cs_r, write_r, read_r;
    logic [1:0]       addr_r;
    logic [31:0]      wdata_r;

    // Upper read-data bits carry nothing useful; fold them so they count as consumed.
    logic             unused_rdata_s;
    assign unused_rdata_s = ^avm.avm_rdata[31:RES_W];

    // The local store only accepts loads while idle (not busy, not in DONE).
    assign load_ok_s = (state_r == S_IDLE);

    // Next-state and element-counter logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_WR_A;
                    k_s     = 4'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR_A: state_s = S_WR_B;
            S_WR_B: state_s = S_RD;
            S_RD:   state_s = S_CAP;
            S_CAP: begin
                k_s = k_r + 4'd1;
                if (k_r == 4'd15) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WR_A;
                end
            end
            S_DONE: state_s = S_IDLE;
            default: begin
                state_s = S_IDLE;
                k_s     = 4'd0;
            end
        endcase
    end

    // Bus strobes are decoded from the next state so they can be registered
    // and line up with the state they belong to.
    always_comb begin
        // A load in the same cycle as start must already reach the first A write.
        if (load_ok_s && load_en && !load_sel && (load_idx == k_s[3:2])) begin
            a_word_s = load_data;
        end else begin
            a_word_s = a_mem_r[k_s[3:2]];
        end
        busy_s  = 1'b0;
        cs_s    = 1'b0;
        write_s = 1'b0;
        read_s  = 1'b0;
        addr_s  = 2'd0;
        wdata_s = 32'd0;
        case (state_s)
            S_WR_A: begin
                busy_s  = 1'b1;
                cs_s    = 1'b1;
                write_s = 1'b1;
                addr_s  = ADDR_A;
                wdata_s = a_word_s;
            end
            S_WR_B: begin
                busy_s  = 1'b1;
                cs_s    = 1'b1;
                write_s = 1'b1;
                addr_s  = ADDR_B;
                wdata_s = b_mem_r[k_s[1:0]];
            end
            S_RD: begin
                busy_s  = 1'b1;
                cs_s    = 1'b1;
                read_s  = 1'b1;
                addr_s  = ADDR_R;
            end
            S_CAP: begin
                busy_s  = 1'b1;
            end
            default: begin
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) begin
            state_r <= S_IDLE;
            k_r     <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cs_r    <= 1'b0;
            write_r <= 1'b0;
            read_r  <= 1'b0;
            addr_r  <= 2'd0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            busy_r  <= busy_s;
            done_r  <= (state_s == S_DONE);
            cs_r    <= cs_s;
            write_r <= write_s;
            read_r  <= read_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

    // Operand store, result buffer and registered result read port.
    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) begin
            for (int n = 0; n < 4; n++) begin
                a_mem_r[n] <= 32'd0;
                b_mem_r[n] <= 32'd0;
            end
            for (int n = 0; n < 16; n++) begin
                buf_r[n] <= {RES_W{1'b0}};
            end
            res_data_r <= {RES_W{1'b0}};
        end else begin
            if (load_ok_s && load_en) begin
                if (load_sel) begin
                    b_mem_r[load_idx] <= load_data;
                end else begin
                    a_mem_r[load_idx] <= load_data;
                end
            end
            if (state_r == S_CAP) begin
                buf_r[k_r] <= avm.avm_rdata[RES_W-1:0];
            end
            res_data_r <= buf_r[res_idx];
        end
    end

`ifdef MMS_CHECKSUM_EN
    logic [CHK_W-1:0] chk_r;

    // Checksum restarts with the first element of a run and adds every captured result.
    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) begin
            chk_r <= {CHK_W{1'b0}};
        end else if ((state_r == S_WR_A) && (k_r == 4'd0)) begin
            chk_r <= {CHK_W{1'b0}};
        end else if (state_r == S_CAP) begin
            chk_r <= chk_r + CHK_W'(avm.avm_rdata[RES_W-1:0]);
        end
    end

    assign checksum = chk_r;
`else
    assign checksum = {CHK_W{1'b0}};
`endif

    assign busy          = busy_r;
    assign done          = done_r;
    assign res_data      = res_data_r;
    assign avm.avm_cs    = cs_r;
    assign avm.avm_write = write_r;
    assign avm.avm_read  = read_r;
    assign avm.avm_addr  = addr_r;
    assign avm.avm_wdata = wdata_r;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_mult_sequencer
//   Self-checking bench: a behavioural partial-multiply slave on the bus, a
//   matrix-level reference model (plain integer arrays), a vector table of
//   known products, hand-written corner sequences and randomized runs.
// ---------------------------------------------------------------------------
module tb_matrix_mult_sequencer;
    localparam int RES_W = 18;
    localparam int CHK_W = 22;

    logic             _CLK = 1'b0;
    logic             _RST = 1'b1;
    logic             load_en = 1'b0;
    logic             load_sel = 1'b0;
    logic [1:0]       load_idx = 2'd0;
    logic [31:0]      load_data = 32'd0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [3:0]       res_idx = 4'd0;
    logic [RES_W-1:0] res_data;
    logic [CHK_W-1:0] checksum;

    int n_checks = 0;
    int n_errors = 0;

    // Reference matrices: ma[i][k] = A[i][k], mb[k][j] = B[k][j]
    int ma [4][4];
    int mb [4][4];

    matrix_mult_sequencer_if bus ();

    matrix_mult_sequencer #(.RES_W(RES_W), .CHK_W(CHK_W)) dut (
        ._CLK      (_CLK),
        ._RST      (_RST),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_idx  (load_idx),
        .load_data (load_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .res_idx   (res_idx),
        .res_data  (res_data),
        .checksum  (checksum),
        .avm       (bus)
    );

    always #5 _CLK = ~_CLK;

    // Slave: two operand registers, result register holds their byte-wise dot product.
    logic [31:0] sl_a, sl_b;
    function automatic logic [31:0] slave_dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s = 32'd0;
        for (int e = 0; e < 4; e++) s = s + 32'(a[8*e +: 8]) * 32'(b[8*e +: 8]);
        return s;
    endfunction

    always @(posedge _CLK) begin
        if (_RST) begin
            sl_a <= 32'd0;
            sl_b <= 32'd0;
            bus.avm_rdata <= 32'd0;
        end else begin
            if (bus.avm_cs && bus.avm_write && bus.avm_addr == 2'd0) sl_a <= bus.avm_wdata;
            if (bus.avm_cs && bus.avm_write && bus.avm_addr == 2'd1) sl_b <= bus.avm_wdata;
            if (bus.avm_cs && bus.avm_read && bus.avm_addr == 2'd2) bus.avm_rdata <= slave_dot(sl_a, sl_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_c(input int idx);
        int s = 0;
        for (int k = 0; k < 4; k++) s += ma[idx / 4][k] * mb[k][idx % 4];
        return 32'(s) & 32'h3FFFF;
    endfunction

    function automatic logic [31:0] model_chk();
`ifdef MMS_CHECKSUM_EN
        logic [31:0] s = 32'd0;
        for (int n = 0; n < 16; n++) s = s + model_c(n);
        return s & 32'h3FFFFF;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_store(input bit sel, input int idx, input logic [31:0] w);
        for (int e = 0; e < 4; e++) begin
            if (!sel) ma[idx][e] = int'(w[8*e +: 8]);
            else      mb[e][idx] = int'(w[8*e +: 8]);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
    endtask

    // Called at a negedge; one load cycle, returns at the next negedge.
    task automatic load_word(input bit sel, input int idx, input logic [31:0] w);
        load_en = 1'b1; load_sel = sel; load_idx = 2'(idx); load_data = w;
        @(negedge _CLK);
        load_en = 1'b0;
        model_store(sel, idx, w);
    endtask

    task automatic load_all(input logic [127:0] aw, input logic [127:0] bw);
        for (int n = 0; n < 4; n++) load_word(1'b0, n, aw[32*n +: 32]);
        for (int n = 0; n < 4; n++) load_word(1'b1, n, bw[32*n +: 32]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_strobes"}, 32'({bus.avm_cs, bus.avm_write, bus.avm_read}), 32'd0);
        check({tag, "_addr_wdata"}, 32'(bus.avm_addr) | bus.avm_wdata, 32'd0);
        check({tag, "_res_chk"}, 32'(res_data) | 32'(checksum), 32'd0);
    endtask

    // Starts a run from a negedge and watches 75 cycles. Cycle c is sampled at
    // the negedge after edge c-1 (start is sampled at edge 0).
    task automatic run_seq(input int restart_cyc, input int load_cyc, input int rst_cyc,
                           input bit trace, input logic [31:0] ta0, input logic [31:0] tb0,
                           input logic [31:0] tb1,
                           output int done_cyc, output int ndone, output int busy_n);
        bit proto_bad = 1'b0;
        logic [2:0]  es;
        logic [1:0]  ea;
        logic [31:0] ew;
        done_cyc = -1; ndone = 0; busy_n = 0;
        start = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge _CLK);
            if (busy) busy_n++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.avm_cs && !(bus.avm_write ^ bus.avm_read)) proto_bad = 1'b1;
            if (!bus.avm_cs && (bus.avm_write || bus.avm_read)) proto_bad = 1'b1;
            if (trace && c <= 6) begin
                ea = 2'd0; ew = 32'd0;
                case (c)
                    1, 5:    begin es = 3'b110; ea = 2'd0; ew = ta0; end
                    2:       begin es = 3'b110; ea = 2'd1; ew = tb0; end
                    6:       begin es = 3'b110; ea = 2'd1; ew = tb1; end
                    3:       begin es = 3'b101; ea = 2'd2; end
                    default: es = 3'b000;
                endcase
                check($sformatf("trace_c%0d_strobes", c),
                      32'({bus.avm_cs, bus.avm_write, bus.avm_read}), 32'(es));
                if (es != 3'b000) check($sformatf("trace_c%0d_addr", c), 32'(bus.avm_addr), 32'(ea));
                if (es == 3'b110) check($sformatf("trace_c%0d_wdata", c), bus.avm_wdata, ew);
            end
            start = (c == restart_cyc);
            load_en = (c == load_cyc);
            if (c == load_cyc) begin
                load_sel = 1'b0; load_idx = 2'd0; load_data = 32'hA5A5A5A5;
            end
            if (c == rst_cyc) begin
                #1 _RST = 1'b1;
                #1 check_all_zero("midrun_reset");
            end
            if (rst_cyc > 0 && c == rst_cyc + 2) _RST = 1'b0;
        end
        check("protocol", 32'(proto_bad), 32'd0);
    endtask

    task automatic check_results(input string tag);
        for (int n = 0; n < 16; n++) begin
            res_idx = 4'(n);
            @(negedge _CLK);
            check($sformatf("%s_C%0d", tag, n), 32'(res_data), model_c(n));
        end
        check({tag, "_checksum"}, 32'(checksum), model_chk());
    endtask

    task automatic full_run(input string tag, input int restart_cyc, input int load_cyc);
        int dc, nd, bn;
        run_seq(restart_cyc, load_cyc, -1, 1'b0, 32'd0, 32'd0, 32'd0, dc, nd, bn);
        check({tag, "_done_cycle"}, 32'(dc), 32'd65);
        check({tag, "_done_count"}, 32'(nd), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bn), 32'd64);
        check_results(tag);
    endtask

    typedef struct packed {
        logic [127:0] a_w;   // row i in [32*i +: 32]
        logic [127:0] b_w;   // column j in [32*j +: 32]
        logic [3:0]   i0;
        logic [17:0]  e0;
        logic [3:0]   i1;
        logic [17:0]  e1;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int dc, nd, bn;
        logic [127:0] aw, bw;
        logic [31:0] neww;

        vecs[0] = '{a_w: {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001},
                    b_w: {32'h34333231, 32'h24232221, 32'h14131211, 32'h04030201},
                    i0: 4'd9, e0: 18'h13, i1: 4'd3, e1: 18'h31};
        vecs[1] = '{a_w: {4{32'hFFFFFFFF}}, b_w: {4{32'hFFFFFFFF}},
                    i0: 4'd0, e0: 18'h3F804, i1: 4'd15, e1: 18'h3F804};
        vecs[2] = '{a_w: {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101},
                    b_w: {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101},
                    i0: 4'd15, e0: 18'h40, i1: 4'd6, e1: 18'h18};
        model_clear();

        // Reset state
        @(negedge _CLK);
        @(negedge _CLK);
        check_all_zero("reset");
        _RST = 1'b0;
        @(negedge _CLK);

        // Table-driven runs (first one also checks the bus trace)
        for (int v = 0; v < 3; v++) begin
            aw = vecs[v].a_w;
            bw = vecs[v].b_w;
            load_all(aw, bw);
            run_seq(-1, -1, -1, (v == 0), aw[31:0], bw[31:0], bw[63:32], dc, nd, bn);
            check($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'd65);
            check($sformatf("vec%0d_done_count", v), 32'(nd), 32'd1);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bn), 32'd64);
            check_results($sformatf("vec%0d", v));
            res_idx = vecs[v].i0;
            @(negedge _CLK);
            check($sformatf("vec%0d_table0", v), 32'(res_data), 32'(vecs[v].e0));
            res_idx = vecs[v].i1;
            @(negedge _CLK);
            check($sformatf("vec%0d_table1", v), 32'(res_data), 32'(vecs[v].e1));
        end

        // Reset mid-clock after a run: everything clears, buffer reads zero
        #2 _RST = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge _CLK);
        @(negedge _CLK);
        _RST = 1'b0;
        model_clear();
        for (int n = 0; n < 16; n++) begin
            res_idx = 4'(n);
            @(negedge _CLK);
            check($sformatf("cleared_C%0d", n), 32'(res_data), 32'd0);
        end

        // Start re-pulsed at cycle 10 and load at cycle 20 are ignored
        load_all(vecs[0].a_w, vecs[0].b_w);
        full_run("ignore", 10, 20);

        // Reset at cycle 30: no done, idle afterwards, then a clean rerun
        aw = {$urandom, $urandom, $urandom, $urandom};
        bw = {$urandom, $urandom, $urandom, $urandom};
        load_all(aw, bw);
        run_seq(-1, -1, 30, 1'b0, 32'd0, 32'd0, 32'd0, dc, nd, bn);
        check("rst30_no_done", 32'(nd), 32'd0);
        check("rst30_busy_after", 32'(busy), 32'd0);
        model_clear();
        load_all(aw, bw);
        full_run("rst30_rerun", -1, -1);

        // Load in the same cycle as start: run uses the new A[0]
        neww = $urandom;
        load_en = 1'b1; load_sel = 1'b0; load_idx = 2'd0; load_data = neww;
        model_store(1'b0, 0, neww);
        full_run("coload", -1, -1);

        // Randomized runs against the reference model
        for (int r = 0; r < 3; r++) begin
            aw = {$urandom, $urandom, $urandom, $urandom};
            bw = {$urandom, $urandom, $urandom, $urandom};
            load_all(aw, bw);
            full_run($sformatf("rand%0d", r), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
